// File: rtl/imply_trail.sv
// Implication trail: ordered store of pushed implications, FIFO hand-off to propagation,
// decision-level marks and newest-first unwinding on backtrack. Optional: IMPLY_TRAIL_HWM_EN.
module imply_trail #(
  parameter int DEPTH    = 512,
  parameter int VAR_BITS = 9,
  parameter int LEVELS   = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_en,
  input  logic [VAR_BITS-1:0] push_var_idx,
  input  logic                push_val,
  input  logic                pop_en,
  output logic                pop_valid,
  output logic [VAR_BITS-1:0] pop_var_idx,
  output logic                pop_val,
  input  logic                mark_en,
  input  logic                backtrack_en,
  output logic                unwind_valid,
  output logic [VAR_BITS-1:0] unwind_var_idx,
  output logic                bt_done,
  output logic                busy,
  output logic [6:0]          level,
  output logic                full,
  output logic                err,
  output logic [VAR_BITS:0]   hwm
);

  localparam int                LVL_AW   = $clog2(LEVELS);
  localparam logic [VAR_BITS:0] DEPTH_C  = (VAR_BITS+1)'(DEPTH);
  localparam logic [VAR_BITS:0] ONE_T    = (VAR_BITS+1)'(1);
  localparam logic [6:0]        LEVELS_C = 7'(LEVELS);

  typedef enum logic [1:0] {IDLE, UNWIND, DONE} state_t;

  state_t              state, state_nxt;
  logic [VAR_BITS:0]   top, prop, target;
  logic [VAR_BITS:0]   top_nxt, prop_nxt, target_nxt, mark_top;
  logic [VAR_BITS-1:0] cursor, cursor_nxt;
  logic [6:0]          level_nxt;
  logic [LVL_AW-1:0]   wr_idx, rd_idx;
  logic                idle, do_push, do_pop, do_mark, drop;

  logic [VAR_BITS-1:0] trail_idx [DEPTH];
  logic                trail_val [DEPTH];
  logic [VAR_BITS:0]   marks     [LEVELS];

  assign idle    = (state == IDLE);
  assign full    = (top == DEPTH_C);
  assign busy    = !idle;
  assign bt_done = (state == DONE);

  assign do_push = push_en && idle && !full && !backtrack_en;
  assign do_pop  = pop_en && pop_valid;
  assign do_mark = mark_en && idle && !backtrack_en && (level < LEVELS_C);
  assign drop    = (push_en && !do_push) || (mark_en && !do_mark) ||
                   (backtrack_en && !idle);

  // wr_idx wraps to 0 at level==LEVELS, but a mark is never written then
  assign wr_idx   = level[LVL_AW-1:0];
  assign rd_idx   = wr_idx - LVL_AW'(1);
  assign mark_top = (level == 7'd0) ? '0 : marks[rd_idx];

  assign pop_valid      = idle && (prop < top);
  assign pop_var_idx    = pop_valid ? trail_idx[prop[VAR_BITS-1:0]] : '0;
  assign pop_val        = pop_valid && trail_val[prop[VAR_BITS-1:0]];
  assign unwind_valid   = (state == UNWIND);
  assign unwind_var_idx = unwind_valid ? trail_idx[cursor] : '0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    top_nxt    = top;
    prop_nxt   = prop;
    target_nxt = target;
    cursor_nxt = cursor;
    level_nxt  = level;
    case (state)
      IDLE: begin
        if (do_push) top_nxt   = top + ONE_T;
        if (do_pop)  prop_nxt  = prop + ONE_T;
        if (do_mark) level_nxt = level + 7'd1;
        if (backtrack_en) begin
          target_nxt = mark_top;
          if (top == mark_top) begin
            state_nxt = DONE;
          end else begin
            cursor_nxt = top[VAR_BITS-1:0] - VAR_BITS'(1);
            state_nxt  = UNWIND;
          end
        end
      end
      UNWIND: begin
        if ({1'b0, cursor} == target) state_nxt = DONE;
        else                          cursor_nxt = cursor - VAR_BITS'(1);
      end
      DONE: begin
        top_nxt  = target;
        prop_nxt = (prop < target) ? prop : target;
        if (level != 7'd0) level_nxt = level - 7'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      top    <= '0;
      prop   <= '0;
      target <= '0;
      cursor <= '0;
      level  <= '0;
      err    <= 1'b0;
    end else begin
      top    <= top_nxt;
      prop   <= prop_nxt;
      target <= target_nxt;
      cursor <= cursor_nxt;
      level  <= level_nxt;
      err    <= err || drop;
    end
  end

  // Storage arrays carry no reset; their contents are only read below top/level
  always_ff @(posedge clock) begin
    if (do_push) begin
      trail_idx[top[VAR_BITS-1:0]] <= push_var_idx;
      trail_val[top[VAR_BITS-1:0]] <= push_val;
    end
    if (do_mark) marks[wr_idx] <= top;
  end

`ifdef IMPLY_TRAIL_HWM_EN
  always_ff @(posedge clock) begin
    if (reset)              hwm <= '0;
    else if (top_nxt > hwm) hwm <= top_nxt;
  end
`else
  assign hwm = '0;
`endif

endmodule
